// File: rtl/pwm_driver_if.sv
// Command/output bundle between the SPI command slave side and one PWM axis driver.
// The master drives the command word and stop; the slave returns the bridge controls.
interface pwm_driver_if #(
  parameter int unsigned PWM_DATA_WIDTH = 16
);
  logic [PWM_DATA_WIDTH-1:0] PWM_CMD;
  logic                      ESTOP;
  logic                      PWM_OUT;
  logic                      DIR_OUT;
  logic                      PERIOD_TICK;
  logic                      DEAD_ACTIVE;

  modport master (
    output PWM_CMD, ESTOP,
    input  PWM_OUT, DIR_OUT, PERIOD_TICK, DEAD_ACTIVE
  );

  modport slave (
    input  PWM_CMD, ESTOP,
    output PWM_OUT, DIR_OUT, PERIOD_TICK, DEAD_ACTIVE
  );
endinterface

// File: rtl/pwm_driver.sv
// Per-axis PWM generator: commands adopted at period boundaries, forced-off dead time
// on every direction reversal, ESTOP forces the bridge off immediately.
module pwm_driver #(
  parameter int unsigned PWM_DATA_WIDTH = 16,
  parameter int unsigned DUTY_WIDTH     = 14,
  parameter int unsigned DEAD_CYCLES    = 64
) (
  input  logic         CLK,
  input  logic         rst_n,
  pwm_driver_if.slave  bus
);

  localparam int unsigned DIR_BIT = PWM_DATA_WIDTH - 2;
  localparam int unsigned DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DUTY_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [DEAD_W-1:0]     DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  logic [PWM_DATA_WIDTH-1:0] s1_q, s2_q, s3_q, cmd_stable_q;

  state_e                state_q, state_d;
  logic [DUTY_WIDTH-1:0] cnt_q, cnt_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic [DEAD_W-1:0]     dead_cnt_q, dead_cnt_d;
  logic                  dir_q, dir_d;
  logic                  pwm_q, pwm_d;
  logic                  tick_q, tick_d;
  logic                  dead_act_q, dead_act_d;

  logic                  cmd_dir;
  logic [DUTY_WIDTH-1:0] cmd_duty;
  logic                  unused_cmd_bits;

  assign cmd_dir         = cmd_stable_q[DIR_BIT];
  assign cmd_duty        = cmd_stable_q[DUTY_WIDTH-1:0];
  assign unused_cmd_bits = ^{cmd_stable_q[PWM_DATA_WIDTH-1], cmd_stable_q[DIR_BIT-1:0]};

  // Three-flop crossing; a word is only accepted once two consecutive samples agree.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      cmd_stable_q <= '0;
    end else begin
      s1_q <= bus.PWM_CMD;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (s2_q == s3_q) begin
        cmd_stable_q <= s2_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      duty_q     <= '0;
      dead_cnt_q <= '0;
      dir_q      <= 1'b0;
      pwm_q      <= 1'b0;
      tick_q     <= 1'b0;
      dead_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      dead_cnt_q <= dead_cnt_d;
      dir_q      <= dir_d;
      pwm_q      <= pwm_d;
      tick_q     <= tick_d;
      dead_act_q <= dead_act_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    dead_cnt_d = dead_cnt_q;
    dir_d      = dir_q;
    pwm_d      = 1'b0;
    tick_d     = 1'b0;

    if (bus.ESTOP) begin
      // Output drops first; direction only starts tracking once already idle.
      state_d    = ST_IDLE;
      cnt_d      = '0;
      duty_d     = '0;
      dead_cnt_d = '0;
      if (state_q == ST_IDLE) begin
        dir_d = cmd_dir;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dir_d   = cmd_dir;
          duty_d  = cmd_duty;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          pwm_d = (cnt_q < duty_q);
          cnt_d = cnt_q + DUTY_WIDTH'(1);
          if (cnt_q == CNT_MAX) begin
            tick_d = 1'b1;
            if (cmd_dir == dir_q) begin
              duty_d = cmd_duty;
            end else begin
              state_d    = ST_DEAD;
              dead_cnt_d = DEAD_LOAD;
            end
          end
        end
        ST_DEAD: begin
          if (dead_cnt_q == '0) begin
            dir_d   = cmd_dir;
            duty_d  = cmd_duty;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            dead_cnt_d = dead_cnt_q - DEAD_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    dead_act_d = (state_d == ST_DEAD);
  end

  assign bus.PWM_OUT     = pwm_q;
  assign bus.DIR_OUT     = dir_q;
  assign bus.PERIOD_TICK = tick_q;
  assign bus.DEAD_ACTIVE = dead_act_q;

endmodule

// File: tb/tb_pwm_driver.sv
// Bench for pwm_driver (DUTY_WIDTH=4, DEAD_CYCLES=3): directed scenarios plus random
// command/ESTOP/reset traffic compared every cycle against a period-level reference.
module tb_pwm_driver;

  localparam int unsigned PDW    = 16;
  localparam int unsigned DW     = 4;
  localparam int unsigned DC     = 3;
  localparam int          PERIOD = 1 << DW;

  logic CLK = 1'b0;
  logic rst_n;

  pwm_driver_if #(.PWM_DATA_WIDTH(PDW)) bus ();

  pwm_driver #(
    .PWM_DATA_WIDTH (PDW),
    .DUTY_WIDTH     (DW),
    .DEAD_CYCLES    (DC)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference: operating mode, position within the period, remaining dead cycles.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  int          m_mode = M_IDLE;
  int          m_pos  = 0;
  int          m_duty = 0;
  int          m_left = 0;
  logic [15:0] m_cs   = '0;
  logic [15:0] h[3]   = '{16'h0, 16'h0, 16'h0};
  int          e_pwm = 0, e_dir = 0, e_tick = 0, e_dead = 0;

  int hi_cnt = 0, tick_cnt = 0, dead_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cdir(input logic [15:0] w);
    return int'(w[14]);
  endfunction

  function automatic int cduty(input logic [15:0] w);
    return int'(w) % PERIOD;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [15:0] c);
    logic [15:0] new_cs;
    new_cs = (h[1] == h[2]) ? h[1] : m_cs;
    e_tick = 0;
    e_pwm  = 0;
    if (!r) begin
      m_mode = M_IDLE; m_pos = 0; m_duty = 0; m_left = 0;
      e_dir = 0;
      new_cs = '0;
      h = '{16'h0, 16'h0, 16'h0};
    end else begin
      if (e) begin
        if (m_mode == M_IDLE) e_dir = cdir(m_cs);
        m_mode = M_IDLE; m_pos = 0; m_duty = 0;
      end else if (m_mode == M_IDLE) begin
        e_dir = cdir(m_cs); m_duty = cduty(m_cs); m_pos = 0; m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        e_pwm = (m_pos < m_duty) ? 1 : 0;
        if (m_pos == PERIOD - 1) begin
          e_tick = 1;
          m_pos  = 0;
          if (cdir(m_cs) == e_dir) m_duty = cduty(m_cs);
          else begin m_mode = M_DEAD; m_left = DC; end
        end else begin
          m_pos++;
        end
      end else begin
        if (m_left == 1) begin
          e_dir = cdir(m_cs); m_duty = cduty(m_cs); m_pos = 0; m_mode = M_RUN;
        end else begin
          m_left--;
        end
      end
      h[2] = h[1]; h[1] = h[0]; h[0] = c;
    end
    e_dead = (m_mode == M_DEAD) ? 1 : 0;
    m_cs   = new_cs;
  endtask

  task automatic step(input logic r, input logic e, input logic [15:0] c);
    rst_n       = r;
    bus.ESTOP   = e;
    bus.PWM_CMD = c;
    @(posedge CLK);
    model_edge(r, e, c);
    #1;
    check("pwm_out",     32'(bus.PWM_OUT),     32'(e_pwm));
    check("dir_out",     32'(bus.DIR_OUT),     32'(e_dir));
    check("period_tick", 32'(bus.PERIOD_TICK), 32'(e_tick));
    check("dead_active", 32'(bus.DEAD_ACTIVE), 32'(e_dead));
    check("cmd_stable",  32'(dut.cmd_stable_q), 32'(m_cs));
    hi_cnt   += int'(bus.PWM_OUT);
    tick_cnt += int'(bus.PERIOD_TICK);
    dead_cnt += int'(bus.DEAD_ACTIVE);
  endtask

  task automatic run(input int n, input logic [15:0] c);
    hi_cnt = 0; tick_cnt = 0; dead_cnt = 0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, c);
  endtask

  initial begin
    logic [15:0] a, b;
    int          n, first;

    // 1: reset then free-run at duty 5
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0005);
    run(40, 16'h0005);
    run(PERIOD, 16'h0005);
    check("s1_high", 32'(hi_cnt), 32'd5);
    check("s1_tick", 32'(tick_cnt), 32'd1);
    check("s1_dir", 32'(bus.DIR_OUT), 32'd0);

    // 2: mid-period change at cnt=3 waits for the boundary
    n = 0;
    while (!(m_mode == M_RUN && m_pos == 3) && n < 4 * PERIOD) begin
      step(1'b1, 1'b0, 16'h0005); n++;
    end
    check("s2_reach_cnt3", 32'(m_pos), 32'd3);
    run(40, 16'h000C);
    check("s2_no_dead", 32'(dead_cnt), 32'd0);
    run(PERIOD, 16'h000C);
    check("s2_high", 32'(hi_cnt), 32'd12);

    // 3: direction reversal inserts exactly DC dead cycles
    run(40, 16'h0008);
    run(40, 16'h4008);
    check("s3_dead_len", 32'(dead_cnt), 32'(DC));
    check("s3_dir", 32'(bus.DIR_OUT), 32'd1);
    run(PERIOD, 16'h4008);
    check("s3_high", 32'(hi_cnt), 32'd8);

    // 4: duty edge cases and ignored bit15
    run(40, 16'h0000);
    run(PERIOD, 16'h0000);
    check("s4_duty0", 32'(hi_cnt), 32'd0);
    run(40, 16'h000F);
    run(PERIOD, 16'h000F);
    check("s4_dutymax", 32'(hi_cnt), 32'(PERIOD - 1));
    run(40, 16'h8007);
    run(PERIOD, 16'h8007);
    check("s4_bit15", 32'(hi_cnt), 32'd7);
    run(40, 16'h0007);
    run(PERIOD, 16'h0007);
    check("s4_plain7", 32'(hi_cnt), 32'd7);

    // 5: ESTOP in the middle of a dead time
    n = 0;
    while (m_mode != M_DEAD && n < 4 * PERIOD) begin
      step(1'b1, 1'b0, 16'h4007); n++;
    end
    check("s5_reach_dead", 32'(m_mode), 32'(M_DEAD));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 16'h4007);
      check("s5_estop_pwm", 32'(bus.PWM_OUT), 32'd0);
      check("s5_estop_dead", 32'(bus.DEAD_ACTIVE), 32'd0);
    end
    check("s5_estop_dir", 32'(bus.DIR_OUT), 32'd1);
    step(1'b1, 1'b0, 16'h4007);
    check("s5_release1", 32'(bus.PWM_OUT), 32'd0);
    step(1'b1, 1'b0, 16'h4007);
    check("s5_release2", 32'(bus.PWM_OUT), 32'd1);
    check("s5_release_dir", 32'(bus.DIR_OUT), 32'd1);

    // 6: toggling command never crosses; a held word lands after 4 edges
    run(20, 16'h4007);
    a = 16'($urandom) | 16'h0200;
    b = a ^ 16'h5555;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? a : b);
      check("s6_sync_hold", 32'(dut.cmd_stable_q), 32'h4007);
    end
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 16'h0003);
      if (first == 0 && dut.cmd_stable_q == 16'h0003) first = k;
    end
    check("s6_sync_latency", 32'(first), 32'd4);
    run(40, 16'h0003);
    run(PERIOD, 16'h0003);
    check("s6_high", 32'(hi_cnt), 32'd3);

    // 7: random commands with sporadic ESTOP and reset
    begin
      logic [15:0] c;
      int          estop_left;
      int          r;
      c = 16'h0003;
      estop_left = 0;
      for (int i = 0; i < 2500; i++) begin
        r = int'($urandom_range(0, 999));
        if (r < 30) c = 16'($urandom);
        if (r >= 980 && r < 990) estop_left = int'($urandom_range(1, 6));
        step((r >= 997) ? 1'b0 : 1'b1, (estop_left > 0) ? 1'b1 : 1'b0, c);
        if (estop_left > 0) estop_left--;
      end
    end

    step(1'b0, 1'b1, 16'h4ABC);
    check("final_reset_pwm", 32'(bus.PWM_OUT), 32'd0);
    check("final_reset_dir", 32'(bus.DIR_OUT), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
